writeback_stage: RTL and testbench



---
 rtl/writeback_stage.sv | 140 ++++++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
//   MEM/WB pipeline register and write-back controller. It captures the
//   memory-stage result on the rising edge of Clock. From that captured
//   state it combinationally drives the register-file write port, the r31
//   (return-address) store and the stack push/pull strobes. Each strobe
//   fires exactly once per retired instruction, however long the stage is
//   stalled.
//
// Parameters
//   DATA_W  datapath width
//   REG_W   register index width
//
// Ports
//   Clock, Reset        clock; synchronous active-high reset
//   Stall, Flush        hold contents / replace contents with a bubble
//   in_*                memory-stage slot (valid, results, control bits)
//   WriteReg/WriteData  register-file write index / data
//   Reg_write_Control   GPR write enable
//   PC_Store            r31 write enable
//   PUSH_Stack/PULL_Stack  stack strobes
//   fwd_valid/fwd_reg/fwd_data  last committed GPR write, for bypassing
//   stack_err           sticky: push and pull requested together
//   retired_count       number of retired valid instructions (wraps)
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [REG_W-1:0]  in_dest_reg,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_link,
  input  logic              in_push,
  input  logic              in_pull,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              Reg_write_Control,
  output logic              PC_Store,
  output logic              PUSH_Stack,
  output logic              PULL_Stack,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              stack_err,
  output logic [31:0]       retired_count
);

  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam logic [REG_W-1:0] REG_SP   = REG_W'(29);
  localparam logic [REG_W-1:0] REG_RA   = REG_W'(31);

  // Stage register
  logic              v;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] mem;
  logic [DATA_W-1:0] pc4;
  logic [REG_W-1:0]  dst;
  logic              rw;
  logic              m2r;
  logic              link;
  logic              push;
  logic              pull;
  // Set once the held instruction has already driven its strobes.
  logic              fired;

  logic              live;
  logic              commit;

  always_comb begin
    live              = v & ~fired;
    WriteReg          = link ? REG_RA : dst;
    WriteData         = link ? pc4 : (m2r ? mem : alu);
    Reg_write_Control = live & rw & ~link & (dst != REG_ZERO)
                        & ~((push | pull) & (dst == REG_SP));
    PC_Store          = live & link;
    PUSH_Stack        = live & push & ~pull;
    PULL_Stack        = live & pull & ~push;
    commit            = Reg_write_Control | PC_Store;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      v             <= 1'b0;
      alu           <= '0;
      mem           <= '0;
      pc4           <= '0;
      dst           <= '0;
      rw            <= 1'b0;
      m2r           <= 1'b0;
      link          <= 1'b0;
      push          <= 1'b0;
      pull          <= 1'b0;
      fired         <= 1'b0;
      fwd_valid     <= 1'b0;
      fwd_reg       <= '0;
      fwd_data      <= '0;
      stack_err     <= 1'b0;
      retired_count <= '0;
    end else begin
      // The instruction presented this cycle has already driven its strobes,
      // so it is committed and counted even if this edge flushes the stage.
      if (commit) begin
        fwd_valid <= 1'b1;
        fwd_reg   <= WriteReg;
        fwd_data  <= WriteData;
      end
      if (live) begin
        retired_count <= retired_count + 32'd1;
        if (push & pull) stack_err <= 1'b1;
      end

      if (Flush) begin
        v     <= 1'b0;
        fired <= 1'b0;
      end else if (Stall) begin
        fired <= 1'b1;
      end else begin
        v     <= in_valid;
        alu   <= in_alu_result;
        mem   <= in_mem_data;
        pc4   <= in_pc_plus4;
        dst   <= in_dest_reg;
        rw    <= in_reg_write;
        m2r   <= in_mem_to_reg;
        link  <= in_link;
        push  <= in_push;
        pull  <= in_pull;
        fired <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush;
  logic        in_valid;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
  logic [4:0]  in_dest_reg;
  logic        in_reg_write, in_mem_to_reg, in_link, in_push, in_pull;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Reg_write_Control, PC_Store, PUSH_Stack, PULL_Stack;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        stack_err;
  logic [31:0] retired_count;

  int passed = 0;
  int total  = 0;

  writeback_stage #(.DATA_W(32), .REG_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .in_dest_reg(in_dest_reg), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
    .in_push(in_push), .in_pull(in_pull),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .Reg_write_Control(Reg_write_Control), .PC_Store(PC_Store),
    .PUSH_Stack(PUSH_Stack), .PULL_Stack(PULL_Stack),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .stack_err(stack_err), .retired_count(retired_count)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_alu_result = '0; in_mem_data = '0; in_pc_plus4 = '0;
    in_dest_reg = '0; in_reg_write = 0; in_mem_to_reg = 0; in_link = 0;
    in_push = 0; in_pull = 0;
  endtask

  task automatic test_reset();
    Reset = 1; Stall = 0; Flush = 0; idle_inputs();
    step(); step();
    Reset = 0;
    total++; if ({Reg_write_Control, PC_Store, PUSH_Stack, PULL_Stack} !== 4'b0)
      $display("FAIL reset_strobes got %b want 0000", {Reg_write_Control, PC_Store, PUSH_Stack, PULL_Stack}); else passed++;
    total++; if (WriteReg !== 5'd0 || WriteData !== 32'd0)
      $display("FAIL reset_wport got %0d/%h want 0/0", WriteReg, WriteData); else passed++;
    total++; if (fwd_valid !== 1'b0 || fwd_reg !== 5'd0 || fwd_data !== 32'd0)
      $display("FAIL reset_fwd got %b/%0d/%h want 0/0/0", fwd_valid, fwd_reg, fwd_data); else passed++;
    total++; if (stack_err !== 1'b0 || retired_count !== 32'd0)
      $display("FAIL reset_err_cnt got %b/%0d want 0/0", stack_err, retired_count); else passed++;
  endtask

  task automatic test_alu();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 5; in_alu_result = 32'h1234;
    step();
    idle_inputs();
    total++; if (Reg_write_Control !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'h1234)
      $display("FAIL alu_wport got %b/%0d/%h want 1/5/00001234", Reg_write_Control, WriteReg, WriteData); else passed++;
    total++; if (PC_Store !== 1'b0 || retired_count !== 32'd0)
      $display("FAIL alu_pre got pcs=%b cnt=%0d want 0/0", PC_Store, retired_count); else passed++;
    step();
    total++; if (Reg_write_Control !== 1'b0)
      $display("FAIL alu_pulse_end got %b want 0", Reg_write_Control); else passed++;
    total++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd5 || fwd_data !== 32'h1234)
      $display("FAIL alu_fwd got %b/%0d/%h want 1/5/00001234", fwd_valid, fwd_reg, fwd_data); else passed++;
    total++; if (retired_count !== 32'd1)
      $display("FAIL alu_retired got %0d want 1", retired_count); else passed++;
  endtask

  task automatic test_stall_load();
    int pulses = 0;
    in_valid = 1; in_reg_write = 1; in_dest_reg = 8; in_mem_to_reg = 1;
    in_mem_data = 32'hDEADBEEF; in_alu_result = 32'h5555;
    step();
    total++; if (WriteData !== 32'hDEADBEEF || WriteReg !== 5'd8)
      $display("FAIL load_wport got %0d/%h want 8/deadbeef", WriteReg, WriteData); else passed++;
    if (Reg_write_Control === 1'b1) pulses++;
    // different instruction presented while stalled must not be captured
    Stall = 1; in_dest_reg = 9; in_mem_to_reg = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (Reg_write_Control === 1'b1) pulses++;
    end
    total++; if (WriteReg !== 5'd8 || WriteData !== 32'hDEADBEEF)
      $display("FAIL load_held got %0d/%h want 8/deadbeef", WriteReg, WriteData); else passed++;
    Stall = 0; idle_inputs();
    step();
    if (Reg_write_Control === 1'b1) pulses++;
    total++; if (pulses !== 1)
      $display("FAIL load_pulses got %0d want 1", pulses); else passed++;
    total++; if (retired_count !== 32'd2)
      $display("FAIL load_retired got %0d want 2", retired_count); else passed++;
    total++; if (fwd_reg !== 5'd8 || fwd_data !== 32'hDEADBEEF)
      $display("FAIL load_fwd got %0d/%h want 8/deadbeef", fwd_reg, fwd_data); else passed++;
  endtask

  task automatic test_jal();
    in_valid = 1; in_link = 1; in_reg_write = 1; in_pc_plus4 = 32'h40;
    in_dest_reg = 5'd4; in_alu_result = 32'h99;
    step();
    idle_inputs();
    total++; if (PC_Store !== 1'b1 || Reg_write_Control !== 1'b0)
      $display("FAIL jal_strobes got pcs=%b rw=%b want 1/0", PC_Store, Reg_write_Control); else passed++;
    total++; if (WriteReg !== 5'd31 || WriteData !== 32'h40)
      $display("FAIL jal_wport got %0d/%h want 31/00000040", WriteReg, WriteData); else passed++;
    step();
    total++; if (PC_Store !== 1'b0 || fwd_reg !== 5'd31 || fwd_data !== 32'h40)
      $display("FAIL jal_fwd got pcs=%b %0d/%h want 0 31/00000040", PC_Store, fwd_reg, fwd_data); else passed++;
    total++; if (retired_count !== 32'd3)
      $display("FAIL jal_retired got %0d want 3", retired_count); else passed++;
  endtask

  task automatic test_zero_and_sp();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 0; in_alu_result = 32'h77;
    step();
    idle_inputs();
    total++; if (Reg_write_Control !== 1'b0)
      $display("FAIL r0_write got %b want 0", Reg_write_Control); else passed++;
    step();
    total++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd31 || fwd_data !== 32'h40)
      $display("FAIL r0_fwd got %b/%0d/%h want 1/31/00000040", fwd_valid, fwd_reg, fwd_data); else passed++;
    in_valid = 1; in_reg_write = 1; in_dest_reg = 29; in_push = 1; in_alu_result = 32'h99;
    step();
    idle_inputs();
    total++; if (PUSH_Stack !== 1'b1 || PULL_Stack !== 1'b0 || Reg_write_Control !== 1'b0)
      $display("FAIL push_sp got push=%b pull=%b rw=%b want 1/0/0", PUSH_Stack, PULL_Stack, Reg_write_Control); else passed++;
    step();
    total++; if (PUSH_Stack !== 1'b0 || fwd_reg !== 5'd31)
      $display("FAIL push_after got push=%b fwd=%0d want 0/31", PUSH_Stack, fwd_reg); else passed++;
    in_valid = 1; in_reg_write = 1; in_dest_reg = 29; in_pull = 1;
    step();
    idle_inputs();
    total++; if (PULL_Stack !== 1'b1 || PUSH_Stack !== 1'b0 || Reg_write_Control !== 1'b0)
      $display("FAIL pull_sp got pull=%b push=%b rw=%b want 1/0/0", PULL_Stack, PUSH_Stack, Reg_write_Control); else passed++;
    step();
    total++; if (retired_count !== 32'd6 || stack_err !== 1'b0)
      $display("FAIL sp_retired got %0d err=%b want 6/0", retired_count, stack_err); else passed++;
  endtask

  task automatic test_push_pull();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 3; in_push = 1; in_pull = 1;
    in_alu_result = 32'hAB;
    step();
    idle_inputs();
    total++; if (PUSH_Stack !== 1'b0 || PULL_Stack !== 1'b0)
      $display("FAIL pp_strobes got push=%b pull=%b want 0/0", PUSH_Stack, PULL_Stack); else passed++;
    total++; if (Reg_write_Control !== 1'b1 || WriteReg !== 5'd3)
      $display("FAIL pp_gpr got rw=%b reg=%0d want 1/3", Reg_write_Control, WriteReg); else passed++;
    step();
    total++; if (stack_err !== 1'b1 || fwd_reg !== 5'd3 || fwd_data !== 32'hAB)
      $display("FAIL pp_err got err=%b fwd=%0d/%h want 1 3/000000ab", stack_err, fwd_reg, fwd_data); else passed++;
    step(); step();
    total++; if (stack_err !== 1'b1 || retired_count !== 32'd7)
      $display("FAIL pp_sticky got err=%b cnt=%0d want 1/7", stack_err, retired_count); else passed++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 1; in_alu_result = 32'h11;
    step();
    total++; if (Reg_write_Control !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 32'h11)
      $display("FAIL b2b_first got %b/%0d/%h want 1/1/00000011", Reg_write_Control, WriteReg, WriteData); else passed++;
    in_dest_reg = 2; in_alu_result = 32'h22;
    step();
    idle_inputs();
    total++; if (Reg_write_Control !== 1'b1 || WriteReg !== 5'd2 || WriteData !== 32'h22)
      $display("FAIL b2b_second got %b/%0d/%h want 1/2/00000022", Reg_write_Control, WriteReg, WriteData); else passed++;
    total++; if (fwd_reg !== 5'd1 || fwd_data !== 32'h11)
      $display("FAIL b2b_fwd1 got %0d/%h want 1/00000011", fwd_reg, fwd_data); else passed++;
    step();
    total++; if (fwd_reg !== 5'd2 || fwd_data !== 32'h22 || retired_count !== 32'd9)
      $display("FAIL b2b_fwd2 got %0d/%h cnt=%0d want 2/00000022/9", fwd_reg, fwd_data, retired_count); else passed++;
  endtask

  task automatic test_flush_stall();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 12; in_alu_result = 32'hC0DE;
    step();
    total++; if (Reg_write_Control !== 1'b1)
      $display("FAIL fl_capture got %b want 1", Reg_write_Control); else passed++;
    // pending store-link sits at the input while the stage stalls
    Stall = 1; in_link = 1; in_pc_plus4 = 32'h80; in_dest_reg = 5'd7;
    step();
    Flush = 1;
    step();
    total++; if (PC_Store !== 1'b0 || Reg_write_Control !== 1'b0)
      $display("FAIL fl_bubble got pcs=%b rw=%b want 0/0", PC_Store, Reg_write_Control); else passed++;
    Stall = 0; Flush = 0; idle_inputs();
    step();
    total++; if (PC_Store !== 1'b0 || retired_count !== 32'd10)
      $display("FAIL fl_retired got pcs=%b cnt=%0d want 0/10", PC_Store, retired_count); else passed++;
    total++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd12 || fwd_data !== 32'hC0DE)
      $display("FAIL fl_fwd got %b/%0d/%h want 1/12/0000c0de", fwd_valid, fwd_reg, fwd_data); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1; in_reg_write = 1; in_dest_reg = 10; in_alu_result = 32'hA0;
    step();
    Stall = 1;
    step();
    Reset = 1;
    step();
    total++; if (Reg_write_Control !== 1'b0 || stack_err !== 1'b0 || retired_count !== 32'd0 || fwd_valid !== 1'b0)
      $display("FAIL rst_stall got rw=%b err=%b cnt=%0d fv=%b want 0/0/0/0", Reg_write_Control, stack_err, retired_count, fwd_valid); else passed++;
    Reset = 0; Stall = 0; idle_inputs();
    step();
    total++; if (Reg_write_Control !== 1'b0 || retired_count !== 32'd0 || WriteReg !== 5'd0)
      $display("FAIL rst_after got rw=%b cnt=%0d reg=%0d want 0/0/0", Reg_write_Control, retired_count, WriteReg); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stall_load();
    test_jal();
    test_zero_and_sp();
    test_push_pull();
    test_back_to_back();
    test_flush_stall();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
